// File: rtl/mips_trace_buffer_if.sv
// Capture/read bus of the MIPS debug trace buffer.
// master: trace source and host reader; slave: the buffer itself.
interface mips_trace_buffer_if #(
    parameter int ADDR_W = 4
);
    logic              Clear;
    logic              CaptureEn;
    logic [31:0]       PCOut;
    logic [31:0]       Instruction;
    logic [31:0]       RegWriteData;
    logic [31:0]       ALUResult;
    logic              RdReady;
    logic              RdValid;
    logic [31:0]       RdData;
    logic              RdLast;
    logic [ADDR_W:0]   Count;
    logic              Overflow;

    modport master (
        output Clear, CaptureEn, PCOut, Instruction, RegWriteData, ALUResult, RdReady,
        input  RdValid, RdData, RdLast, Count, Overflow
    );

    modport slave (
        input  Clear, CaptureEn, PCOut, Instruction, RegWriteData, ALUResult, RdReady,
        output RdValid, RdData, RdLast, Count, Overflow
    );
endinterface

// File: rtl/mips_trace_buffer.sv
// Circular trace buffer for the single-cycle MIPS core. Each capture stores
// {PC, instruction, write-back data, ALU result}; records stream back out as
// four 32-bit words over a valid/ready port, oldest record first.
module mips_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic                 Clk,
    input logic                 Reset,
    mips_trace_buffer_if.slave  bus
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [1:0]        wi_q, wi_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [127:0]      mem_q [DEPTH];

    logic              full;
    logic              cap;
    logic              hs;
    logic              pop;
    logic [127:0]      rec;
    logic [31:0]       word;

    // Next-state logic: pointers, record count, sticky overflow and read FSM.
    always_comb begin
        full    = (count_q == (ADDR_W+1)'(DEPTH));
        cap     = bus.CaptureEn && !full;
        hs      = (state_q == SEND) && bus.RdReady;
        pop     = hs && (wi_q == 2'd3);
        state_d = state_q;
        wi_d    = wi_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.Clear) begin
            state_d = IDLE;
            wi_d    = '0;
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (cap) wp_d = wp_q + 1'b1;
            if (pop) rp_d = rp_q + 1'b1;
            if (cap && !pop)      count_d = count_q + 1'b1;
            else if (pop && !cap) count_d = count_q - 1'b1;
            // Fullness is judged before any same-edge pop frees a slot.
            if (bus.CaptureEn && full) ovf_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        state_d = SEND;
                        wi_d    = '0;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (wi_q != 2'd3) begin
                            wi_d = wi_q + 1'b1;
                        end else begin
                            wi_d = '0;
                            if (count_q <= (ADDR_W+1)'(1)) state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            wi_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wi_q    <= wi_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Record storage; contents need no reset because only written slots are read.
    always_ff @(posedge Clk) begin
        if (cap && !bus.Clear) begin
            mem_q[wp_q] <= {bus.PCOut, bus.Instruction, bus.RegWriteData, bus.ALUResult};
        end
    end

    // Output word select from registered state; zero whenever no word is offered.
    always_comb begin
        rec = mem_q[rp_q];
        case (wi_q)
            2'd0:    word = rec[127:96];
            2'd1:    word = rec[95:64];
            2'd2:    word = rec[63:32];
            default: word = rec[31:0];
        endcase
        bus.RdValid  = (state_q == SEND);
        bus.RdData   = (state_q == SEND) ? word : '0;
        bus.RdLast   = (state_q == SEND) && (wi_q == 2'd3);
        bus.Count    = count_q;
        bus.Overflow = ovf_q;
    end
endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Debug trace capture for the single-cycle MIPS core: samples the core's per-instruction debug outputs (PCOut, Instruction, RegWriteData, ALUResult) into a circular record buffer and streams each record back out as four 32-bit words over a valid/ready read port. It sits beside `top` on the FPGA build and consumes what the simulation bench only watches, so a host-side reader (UART bridge, ILA, or bench) can replay execution.

## Interface
Parameters:
- DEPTH, 16, number of records held; power of two, ≥ 2
- ADDR_W, 4, log2(DEPTH)

Ports:
- Clk  input  1  single clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- Clear  input  1  synchronous flush of buffer, counters, Overflow and read FSM
- CaptureEn  input  1  capture one record this cycle
- PCOut  input  32  core PC
- Instruction  input  32  core instruction
- RegWriteData  input  32  core register write-back data
- ALUResult  input  32  core ALU result
- RdReady  input  1  reader accepts RdData this cycle
- RdValid  output  1  RdData holds a valid trace word
- RdData  output  32  current trace word
- RdLast  output  1  current word is word 3 of its record
- Count  output  ADDR_W+1  records stored, 0..DEPTH
- Overflow  output  1  sticky: a capture was dropped because buffer was full

## Operation
- Storage: DEPTH records × 4 words, write pointer wp and read pointer rp (ADDR_W bits, wrap modulo DEPTH), Count register.
- Capture: at an edge with CaptureEn=1 and Count<DEPTH, record {PCOut, Instruction, RegWriteData, ALUResult} written at wp, wp+1.
- Full: Count==DEPTH at start of cycle blocks capture even if a pop completes the same edge; record discarded, Overflow←1 (held until Clear or Reset).
- Read FSM, states IDLE and SEND, word index wi (2 bits):
  - IDLE: RdValid=0. If Count≠0 → SEND, wi=0.
  - SEND: RdValid=1, RdData = word wi of record rp; order wi 0..3 = PCOut, Instruction, RegWriteData, ALUResult. RdLast=1 iff wi==3.
  - Handshake on RdValid&RdReady: wi<3 → wi+1; wi==3 → pop (rp+1, Count−1), then stay SEND with wi=0 if Count>1 before pop, else IDLE.
  - RdValid=1 with RdReady=0: RdData, RdLast, wi held stable; RdValid never drops mid-record.
- Count update per edge: +1 on capture only, −1 on pop only, unchanged on both or neither.
- Clear (sync) has priority over capture and pop: wp=rp=0, Count=0, Overflow=0, FSM IDLE, wi=0; inputs that cycle ignored.
- Reset mid-record: everything cleared asynchronously; partially sent record lost; no spurious RdValid after release.

## Timing
- Reset values: RdValid=0, RdData=0 (driven 0 whenever RdValid=0), RdLast=0, Count=0, Overflow=0, FSM IDLE, wp=rp=wi=0.
- Capture at edge k → Count=1 after edge k → SEND entered at edge k+1 → RdValid=1 from k+1.
- Back-to-back throughput with RdReady=1: one word per cycle, one record per 4 cycles, no bubble between records.
- Capture never blocked by read activity except when full.
- All outputs are registers or muxes of registers; no combinational path from RdReady or CaptureEn to any output.

## Test plan
- Reset then CaptureEn pulse with PC=0x00000004, Instr=0x20080005, RWD=0x5, ALU=0x5, RdReady=1 → RdValid from next-next edge, words 0x4, 0x20080005, 0x5, 0x5 on four consecutive cycles, RdLast only on 4th, Count 1→0, FSM IDLE.
- RdReady toggled 1,0,0,1,... during a record → RdData/RdLast stable while RdReady=0; all four words delivered in order, none duplicated.
- RdReady=0, CaptureEn=1 for 20 cycles with DEPTH=16 and PC incrementing by 4 from 0 → Count=16, Overflow=1; draining yields PCs 0x00..0x3C in order, Overflow still 1 afterwards.
- Full buffer, pop completing the same edge as a capture → capture dropped, Count=15, Overflow=1; with Count=5, capture and pop same edge → Count stays 5.
- Clear asserted mid-record (wi=2) with CaptureEn=1 → next cycle Count=0, RdValid=0, Overflow=0, nothing stored.
- Async Reset pulsed between clock edges while SEND → outputs zero immediately, before next edge; normal capture works after release.
